// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Supplies default values for the global ADDR_WIDTH / ADDR_INIT macros when the build leaves them unset.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef ADDR_INIT
`define ADDR_INIT 32'h8000_0000
`endif

package ifu_fetch_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StValid,
    StDrop
  } fetch_state_e;

  localparam logic [31:0] INST_NOP        = 32'h0000_0013;
  localparam int unsigned PC_STEP_DEFAULT = 4;

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-stage bundle: memory req/gnt/rvalid port, IFU->IDU valid/ready handshake and redirect.
// Signal names carry their direction as seen from the fetch unit (master modport).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

interface ifu_fetch_if #(
  parameter int unsigned INST_WIDTH = 32
);

  logic                   i_sys_ready;
  logic                   o_sys_valid;
  logic                   i_redirect_valid;
  logic [`ADDR_WIDTH-1:0] i_redirect_pc;
  logic                   o_mem_req;
  logic [`ADDR_WIDTH-1:0] o_mem_addr;
  logic                   i_mem_gnt;
  logic                   i_mem_rvalid;
  logic [INST_WIDTH-1:0]  i_mem_rdata;
  logic [`ADDR_WIDTH-1:0] o_ifu_pc;
  logic [`ADDR_WIDTH-1:0] o_ifu_pc_next;
  logic [INST_WIDTH-1:0]  o_ifu_inst;
  logic                   o_ifu_fault;

  modport master (
    input  i_sys_ready, i_redirect_valid, i_redirect_pc, i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    output o_sys_valid, o_mem_req, o_mem_addr, o_ifu_pc, o_ifu_pc_next, o_ifu_inst, o_ifu_fault
  );

  modport slave (
    output i_sys_ready, i_redirect_valid, i_redirect_pc, i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    input  o_sys_valid, o_mem_req, o_mem_addr, o_ifu_pc, o_ifu_pc_next, o_ifu_inst, o_ifu_fault
  );

endinterface

// File: rtl/ifu_fetch_pc.sv
// Architectural fetch PC: register, sequential increment and redirect mux.
// Redirect takes priority over the sequential step.
module ifu_fetch_pc #(
  parameter int unsigned          AddrWidth = 32,
  parameter int unsigned          PcStep    = 4,
  parameter logic [AddrWidth-1:0] AddrInit  = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_next_i,
  input  logic                 load_redirect_i,
  input  logic [AddrWidth-1:0] redirect_pc_i,
  output logic [AddrWidth-1:0] pc_o,
  output logic [AddrWidth-1:0] pc_next_o
);

  logic [AddrWidth-1:0] pc_q;

  // Plain modular add: the PC wraps at the top of the address space.
  assign pc_next_o = pc_q + AddrWidth'(PcStep);
  assign pc_o      = pc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= AddrInit;
    end else if (load_redirect_i) begin
      pc_q <= redirect_pc_i;
    end else if (load_next_i) begin
      pc_q <= pc_next_o;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: one outstanding imem read, bundle presented over valid/ready.
// Define IFU_FETCH_FAULT_EN to turn misaligned PCs into a NOP bundle flagged with o_ifu_fault.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned PC_STEP    = PC_STEP_DEFAULT
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst,
  ifu_fetch_if.master bus
);

  localparam int unsigned     AW     = `ADDR_WIDTH;
  localparam logic [AW-1:0]   PcInit = AW'(`ADDR_INIT);

  fetch_state_e          state_q;
  logic [AW-1:0]         pc;
  logic [AW-1:0]         pc_next;
  logic [AW-1:0]         ifu_pc_q;
  logic [AW-1:0]         ifu_pc_next_q;
  logic [INST_WIDTH-1:0] inst_q;
  logic                  redirect;
  logic                  misaligned;
  logic                  mem_req;
  logic                  gnt_acc;
  logic                  load_next;

  assign redirect = bus.i_redirect_valid;

`ifdef IFU_FETCH_FAULT_EN
  logic fault_q;
  assign misaligned      = |pc[1:0];
  assign bus.o_ifu_fault = fault_q;
`else
  assign misaligned      = 1'b0;
  assign bus.o_ifu_fault = 1'b0;
`endif

  assign mem_req   = (state_q == StReq) && !misaligned;
  assign gnt_acc   = mem_req && bus.i_mem_gnt;
  assign load_next = (state_q == StValid) && bus.i_sys_ready && !redirect;

  ifu_fetch_pc #(
    .AddrWidth (AW),
    .PcStep    (PC_STEP),
    .AddrInit  (PcInit)
  ) u_pc (
    .clk_i           (i_sys_clk),
    .rst_i           (i_sys_rst),
    .load_next_i     (load_next),
    .load_redirect_i (redirect),
    .redirect_pc_i   (bus.i_redirect_pc),
    .pc_o            (pc),
    .pc_next_o       (pc_next)
  );

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q       <= StIdle;
      inst_q        <= '0;
      ifu_pc_q      <= PcInit;
      ifu_pc_next_q <= PcInit;
`ifdef IFU_FETCH_FAULT_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: state_q <= StReq;
        StReq: begin
          // A granted request under redirect still owes a response, so drain it in StDrop.
          if (redirect) begin
            state_q <= gnt_acc ? StDrop : StReq;
`ifdef IFU_FETCH_FAULT_EN
          end else if (misaligned) begin
            state_q       <= StValid;
            ifu_pc_q      <= pc;
            ifu_pc_next_q <= pc_next;
            inst_q        <= INST_WIDTH'(INST_NOP);
            fault_q       <= 1'b1;
`endif
          end else if (gnt_acc) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (redirect) begin
            state_q <= bus.i_mem_rvalid ? StReq : StDrop;
          end else if (bus.i_mem_rvalid) begin
            state_q       <= StValid;
            ifu_pc_q      <= pc;
            ifu_pc_next_q <= pc_next;
            inst_q        <= bus.i_mem_rdata;
`ifdef IFU_FETCH_FAULT_EN
            fault_q       <= 1'b0;
`endif
          end
        end
        StValid: begin
          if (redirect || bus.i_sys_ready) begin
            state_q <= StReq;
          end
        end
        StDrop: begin
          if (!redirect && bus.i_mem_rvalid) begin
            state_q <= StReq;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.o_sys_valid   = (state_q == StValid);
  assign bus.o_mem_req     = mem_req;
  assign bus.o_mem_addr    = {pc[AW-1:2], 2'b00};
  assign bus.o_ifu_pc      = ifu_pc_q;
  assign bus.o_ifu_pc_next = ifu_pc_next_q;
  assign bus.o_ifu_inst    = inst_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized scoreboard bench for ifu_fetch: a memory responder with random gnt/rvalid latency,
// random ready and redirects; a PC-level model predicts every accepted bundle.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef ADDR_INIT
`define ADDR_INIT 32'h8000_0000
`endif

module tb_ifu_fetch;

  localparam int unsigned AW = `ADDR_WIDTH;
  typedef logic [AW-1:0] addr_t;
  localparam addr_t INIT = AW'(`ADDR_INIT);

  typedef struct packed {
    addr_t       pc;
    addr_t       pc_next;
    logic [31:0] inst;
    logic        fault;
  } bundle_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifu_fetch_if bus ();

  ifu_fetch dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst),
    .bus       (bus)
  );

  int      checks = 0;
  int      errors = 0;
  int      accepts = 0;
  int      cycle = 0;
  bit      zero_wait = 1'b0;
  bundle_t exp_q[$];
  addr_t   exp_pc;
  bit      pend = 1'b0;
  addr_t   paddr;
  int      delay = 0;

  // Memory image: every word address holds a distinct scrambled value.
  function automatic logic [31:0] mem_word(input addr_t a);
    logic [31:0] x;
    x = 32'(a);
    return (x * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic bundle_t expect_for(input addr_t pc);
    bundle_t b;
    addr_t   word;
    word      = pc & ~addr_t'(3);
    b.pc      = pc;
    b.pc_next = pc + addr_t'(4);
    b.inst    = mem_word(word);
    b.fault   = 1'b0;
`ifdef IFU_FETCH_FAULT_EN
    if (pc[1:0] != 2'b00) begin
      b.inst  = 32'h0000_0013;
      b.fault = 1'b1;
    end
`endif
    return b;
  endfunction

  function automatic addr_t pick_target();
    case ($urandom_range(0, 5))
      0:       return AW'(32'h8000_0100);
      1:       return AW'(32'hFFFF_FFFC);
      2:       return AW'(32'h8000_0002);
      3:       return addr_t'($urandom) & ~addr_t'(3);
      4:       return addr_t'($urandom);
      default: return INIT + addr_t'($urandom_range(0, 63) * 4);
    endcase
  endfunction

  // Drive inputs for the next edge, then update the model just before that edge.
  task automatic step(input bit zw, input int redir_pct, input bit do_rst);
    rst                  = do_rst;
    bus.i_sys_ready      = zw ? 1'b1 : ($urandom_range(0, 99) < 60);
    bus.i_redirect_valid = (zw || do_rst) ? 1'b0 : ($urandom_range(0, 99) < redir_pct);
    bus.i_redirect_pc    = pick_target();
    bus.i_mem_gnt        = !pend && (zw || ($urandom_range(0, 2) == 0));
    if (pend && delay == 0) begin
      bus.i_mem_rvalid = 1'b1;
      bus.i_mem_rdata  = mem_word(paddr);
    end else begin
      bus.i_mem_rvalid = 1'b0;
      bus.i_mem_rdata  = $urandom;
      if (pend) delay--;
    end
    @(negedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      exp_pc = INIT;
      exp_q.push_back(expect_for(exp_pc));
      pend = 1'b0;
    end else begin
      if (bus.i_redirect_valid) begin
        exp_pc = bus.i_redirect_pc;
        exp_q.delete();
        exp_q.push_back(expect_for(exp_pc));
      end else if (bus.o_sys_valid && bus.i_sys_ready) begin
        exp_pc = exp_pc + addr_t'(4);
        exp_q.push_back(expect_for(exp_pc));
      end
      if (bus.i_mem_rvalid) pend = 1'b0;
      if (bus.o_mem_req && bus.i_mem_gnt) begin
        pend  = 1'b1;
        paddr = bus.o_mem_addr;
        delay = zw ? 0 : $urandom_range(0, 4);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every accepted bundle and checks hold-stability rules.
  initial begin
    bundle_t cur, prev_b, e;
    bit      hold_req = 1'b0;
    bit      hold_valid = 1'b0;
    addr_t   prev_addr = '0;
    int      last_acc = -1;
    prev_b = '0;
    forever begin
      @(negedge clk);
      cycle++;
      cur = '{pc: bus.o_ifu_pc, pc_next: bus.o_ifu_pc_next, inst: bus.o_ifu_inst,
              fault: bus.o_ifu_fault};
      if (!rst) begin
        if (hold_req) begin
          checks++;
          if (!(bus.o_mem_req && bus.o_mem_addr == prev_addr)) begin
            errors++;
            $display("FAIL req_hold cyc=%0d: got req=%b addr=%h, need req=1 addr=%h",
                     cycle, bus.o_mem_req, bus.o_mem_addr, prev_addr);
          end
        end
        if (hold_valid) begin
          checks++;
          if (!(bus.o_sys_valid && cur == prev_b)) begin
            errors++;
            $display("FAIL valid_hold cyc=%0d: got valid=%b bundle=%h, need valid=1 bundle=%h",
                     cycle, bus.o_sys_valid, cur, prev_b);
          end
        end
        if (bus.o_sys_valid && bus.i_sys_ready && !bus.i_redirect_valid) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL bundle cyc=%0d: got pc=%h with no bundle expected", cycle, cur.pc);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              errors++;
              $display("FAIL bundle cyc=%0d: got pc=%h nxt=%h inst=%h flt=%b, need pc=%h nxt=%h inst=%h flt=%b",
                       cycle, cur.pc, cur.pc_next, cur.inst, cur.fault,
                       e.pc, e.pc_next, e.inst, e.fault);
            end
          end
          if (zero_wait && last_acc >= 0) begin
            checks++;
            if (cycle - last_acc != 3) begin
              errors++;
              $display("FAIL throughput cyc=%0d: got gap %0d, need 3", cycle, cycle - last_acc);
            end
          end
          last_acc = cycle;
          accepts++;
        end
      end
      hold_req   = !rst && bus.o_mem_req && !bus.i_mem_gnt && !bus.i_redirect_valid;
      hold_valid = !rst && bus.o_sys_valid && !bus.i_sys_ready && !bus.i_redirect_valid;
      prev_addr  = bus.o_mem_addr;
      prev_b     = cur;
      if (!zero_wait) last_acc = -1;
    end
  end

  initial begin
    bus.i_sys_ready      = 1'b0;
    bus.i_redirect_valid = 1'b0;
    bus.i_redirect_pc    = '0;
    bus.i_mem_gnt        = 1'b0;
    bus.i_mem_rvalid     = 1'b0;
    bus.i_mem_rdata      = '0;
    @(posedge clk);
    #1;
    repeat (3) step(1'b0, 0, 1'b1);

    @(negedge clk);
    checks++;
    if (bus.o_sys_valid !== 1'b0 || bus.o_mem_req !== 1'b0 || bus.o_ifu_fault !== 1'b0 ||
        bus.o_ifu_inst !== '0 || bus.o_ifu_pc !== INIT || bus.o_ifu_pc_next !== INIT) begin
      errors++;
      $display("FAIL reset: got valid=%b req=%b flt=%b inst=%h pc=%h nxt=%h, need 0 0 0 0 %h %h",
               bus.o_sys_valid, bus.o_mem_req, bus.o_ifu_fault, bus.o_ifu_inst,
               bus.o_ifu_pc, bus.o_ifu_pc_next, INIT, INIT);
    end
    @(posedge clk);
    #1;

    // Zero-wait memory with ready high: IDLE -> REQ at ADDR_INIT, then one bundle every 3 cycles.
    zero_wait = 1'b1;
    step(1'b1, 0, 1'b0);
    checks++;
    if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== INIT) begin
      errors++;
      $display("FAIL first_req: got req=%b addr=%h, need req=1 addr=%h",
               bus.o_mem_req, bus.o_mem_addr, INIT);
    end
    repeat (40) step(1'b1, 0, 1'b0);
    zero_wait = 1'b0;

    repeat (2000) step(1'b0, 5, 1'b0);
    step(1'b0, 0, 1'b1);
    repeat (2000) step(1'b0, 5, 1'b0);
    step(1'b0, 0, 1'b1);
    repeat (500) step(1'b0, 15, 1'b0);

    checks++;
    if (accepts < 100) begin
      errors++;
      $display("FAIL progress: got %0d accepted bundles, need at least 100", accepts);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
